wb_march_bist: RTL and testbench
================================

Name: wb_march_bist

Overview:
- Wishbone classic master that drives the dual-port SRAM Wishbone wrapper from upstream, on the same wb_clk_i domain.
- Runs a 4-phase March C- style test over every SRAM row, then reports pass/fail, the first failing address and data, and an error count.
- Replaces ad-hoc firmware poking for SRAM characterisation on the testchip. Results are exposed as status ports for logic analyser or GPIO readout.

Parameters:
- NO_OF_ROWS, 256, SRAM rows under test; power of two, ≥4.
- BASE_ADDR, 32'h3000_0000, Wishbone address of row 0. Bits [15:0] must be zero; the wrapper selects its read port on adr[15:0].
- TIMEOUT, 15, maximum cycles to wait for ack per transaction.

Ports:
- wb_clk_i  in  1  clock; every register is updated on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that starts a run; ignored while busy_o=1.
- pattern_i  in  32  background pattern P; sampled on start.
- busy_o  out  1  high while a run is in progress.
- done_o  out  1  high after a run ends; held until the next start or reset.
- pass_o  out  1  valid when done_o=1: error_count_o==0 and no timeout.
- timeout_o  out  1  the run was aborted because ack never arrived.
- error_count_o  out  8  number of read mismatches; saturates at 255.
- fail_addr_o  out  32  Wishbone address of the first mismatch.
- fail_data_o  out  32  data read at the first mismatch.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe; always equal to cyc.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select; always 4'hF.
- wbm_adr_o  out  32  address = BASE_ADDR + row*4.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Reset during a run drops cyc/stb at that edge and discards the run's partial results.
- Phases (row = row index):
  - P0: ascending, write P.
  - P1: ascending, read and expect P, then write ~P.
  - P2: descending, read and expect ~P, then write P.
  - P3: descending, read and expect P.
- Transactions per run: 6*NO_OF_ROWS. A read-then-write pair on one row is two separate transactions.
- FSM states:
  - IDLE: start_i → clear the result registers, latch P, row=0, phase=P0 → REQ.
  - REQ: cyc=stb=1, with adr/we/dat stable. On the edge where ack_i=1: capture dat_i if reading, advance the sequence, → GAP.
  - GAP: exactly one cycle with cyc=stb=0. This is mandatory so the downstream wrapper's toggling request/ack logic re-arms. Then → REQ if transactions remain, else → DONE.
  - DONE: done_o=1, busy_o=0. start_i → restart as from IDLE.
- Read check:
  - Compare is on the full 32 bits.
  - On mismatch, error_count increments, saturating at 255.
  - fail_addr_o/fail_data_o are written only on the first mismatch of a run.
- Row wrap:
  - Ascending phases end after row NO_OF_ROWS-1.
  - P2 starts at NO_OF_ROWS-1 and ends after row 0; P3 does the same.
  - Row counter width is $clog2(NO_OF_ROWS); the end-of-phase test uses the terminal value, not overflow.
- Sequencing: cyc never stays high across two transactions, and back-to-back REQ states never occur.
- start_i with busy_o=1: no effect.
- pass_o = (error_count==0) && !timeout_o, registered on the transition into DONE.

Optional Feature:
- Macro: BIST_TIMEOUT_EN.
- Defined:
  - A 4-bit+ cycle counter runs in REQ.
  - If it reaches TIMEOUT without ack: drop cyc/stb, set timeout_o=1, go to DONE with pass_o=0.
  - The counter clears on every REQ entry.
- Undefined: no counter; REQ waits forever and timeout_o is tied 0.

Decomposition:
- Package wb_bist_pkg:
  - FSM state enum {IDLE, REQ, GAP, DONE}.
  - Phase enum {P0..P3}.
  - Per-phase constants: direction, whether the phase reads, the expected value select, and the write value select.
- One natural sub-module, wb_bist_addr_gen:
  - Contains the row counter with up/down, terminal detect, and the BASE_ADDR+row*4 formation.
  - The FSM and checker stay in the top.

Test Plan:
- Wrapper + fault-free SRAM model, NO_OF_ROWS=16, P=32'hA5A5_5A5A → 96 transactions (monitor counts), done_o=1, pass_o=1, error_count_o=0. Rows 8–15 read via port 1.
- Same bench, row 9 bit 0 stuck-at-1 → error_count_o=2 (P1 and P3 reads), fail_addr_o=32'h3000_0024, fail_data_o=32'hA5A5_5A5B, pass_o=0.
- Ack never asserted, BIST_TIMEOUT_EN defined, TIMEOUT=15 → cyc drops 15 cycles after the first REQ, timeout_o=1, done_o=1, pass_o=0.
- Protocol monitor over the full run → exactly one cyc=0 cycle after every ack, sel always 4'hF, stb==cyc always.
- wb_rst_i pulsed at transaction 40 → cyc=0 on the next edge, all outputs 0. A following start_i runs a clean 96-transaction pass.
- start_i pulsed during a run → no restart, total transactions still 96. start_i in DONE → results cleared and a new run begins.

Source files
------------

// File: rtl/wb_bist_pkg.sv
// March C- Wishbone BIST: shared types and per-phase sequencing table.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, phase enum, phase_cfg() giving direction,
//           read/write presence and true/inverted pattern selects per phase.
package wb_bist_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_e;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;

  // down    : rows visited from NO_OF_ROWS-1 down to 0
  // rd / wr : phase issues a read / a write on each row (read first)
  // exp_inv : expected read data is ~P instead of P
  // wr_inv  : written data is ~P instead of P
  typedef struct packed {
    logic down;
    logic rd;
    logic wr;
    logic exp_inv;
    logic wr_inv;
  } phase_cfg_t;

  function automatic phase_cfg_t phase_cfg(input phase_e ph);
    phase_cfg_t c;
    case (ph)
      P0:      c = '{down: 1'b0, rd: 1'b0, wr: 1'b1, exp_inv: 1'b0, wr_inv: 1'b0};
      P1:      c = '{down: 1'b0, rd: 1'b1, wr: 1'b1, exp_inv: 1'b0, wr_inv: 1'b1};
      P2:      c = '{down: 1'b1, rd: 1'b1, wr: 1'b1, exp_inv: 1'b1, wr_inv: 1'b0};
      default: c = '{down: 1'b1, rd: 1'b1, wr: 1'b0, exp_inv: 1'b0, wr_inv: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wb_bist_addr_gen.sv
// Row counter for the March BIST: up/down stepping, terminal detect, address.
// Latency: row updates on the clock edge after init_i/step_i; last_o/adr_o combinational.
// Backpressure: none; advances only when the controller asserts step_i.
// Ports: clk_i/rst_i (sync, active high); init_i loads the start row of a phase
//        (NO_OF_ROWS-1 when init_down_i else 0); step_i moves one row in step_down_i
//        direction; last_o flags the final row for that direction; adr_o = BASE_ADDR + row*4.
module wb_bist_addr_gen #(
  parameter int unsigned NO_OF_ROWS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        init_down_i,
  input  logic        step_i,
  input  logic        step_down_i,
  output logic        last_o,
  output logic [31:0] adr_o
);

  localparam int unsigned RW = $clog2(NO_OF_ROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(NO_OF_ROWS - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [RW-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (init_i) begin
      row_d = init_down_i ? ROW_LAST : '0;
    end else if (step_i) begin
      row_d = step_down_i ? (row_q - ROW_ONE) : (row_q + ROW_ONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  // Terminal value for the current direction; the counter never relies on wrap.
  assign last_o = step_down_i ? (row_q == '0) : (row_q == ROW_LAST);
  assign adr_o  = BASE_ADDR + {{(30 - RW){1'b0}}, row_q, 2'b00};

endmodule

// File: rtl/wb_march_bist.sv
// Wishbone classic master running a 4-phase March C- test over every SRAM row.
// Latency: one transaction per REQ+GAP pair; 6*NO_OF_ROWS transactions per run.
// Backpressure: REQ holds until wbm_ack_i (or until TIMEOUT cycles with BIST_TIMEOUT_EN).
// Ports: wb_clk_i/wb_rst_i (sync, active high); start_i+pattern_i launch a run;
//        busy_o/done_o/pass_o/timeout_o/error_count_o/fail_addr_o/fail_data_o report;
//        wbm_* is the Wishbone master. Optional macro: BIST_TIMEOUT_EN (ack timeout).
module wb_march_bist
  import wb_bist_pkg::*;
#(
  parameter int unsigned NO_OF_ROWS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] pattern_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [7:0]  error_count_o,
  output logic [31:0] fail_addr_o,
  output logic [31:0] fail_data_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic        wr_step_q, wr_step_d;   // second (write) half of a read-then-write row
  logic        last_q, last_d;         // final transaction of the run has been acked
  logic [31:0] pat_q, pat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        cyc_q, cyc_d;
  logic [7:0]  err_q, err_d;
  logic [31:0] fail_addr_q, fail_addr_d;
  logic [31:0] fail_data_q, fail_data_d;

  logic        gen_init, gen_init_down, gen_step, gen_last;
  logic [31:0] gen_adr;

  phase_cfg_t  cfg, nxt_cfg;
  phase_e      phase_nxt;
  logic        is_read;
  logic [31:0] exp_dat, wr_dat;

`ifdef BIST_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [TW-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT only matters when the ack timeout is compiled in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign cfg       = phase_cfg(phase_q);
  assign phase_nxt = phase_e'(phase_q + 2'd1);
  assign nxt_cfg   = phase_cfg(phase_nxt);
  assign is_read   = cfg.rd && !wr_step_q;
  assign exp_dat   = cfg.exp_inv ? ~pat_q : pat_q;
  assign wr_dat    = cfg.wr_inv  ? ~pat_q : pat_q;

  wb_bist_addr_gen #(
    .NO_OF_ROWS (NO_OF_ROWS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_gen (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .init_i      (gen_init),
    .init_down_i (gen_init_down),
    .step_i      (gen_step),
    .step_down_i (cfg.down),
    .last_o      (gen_last),
    .adr_o       (gen_adr)
  );

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    wr_step_d     = wr_step_q;
    last_d        = last_q;
    pat_d         = pat_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    cyc_d         = cyc_q;
    err_d         = err_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    gen_init      = 1'b0;
    gen_init_down = 1'b0;
    gen_step      = 1'b0;
`ifdef BIST_TIMEOUT_EN
    tmo_d         = '0;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          pat_d       = pattern_i;
          phase_d     = P0;
          wr_step_d   = 1'b0;
          last_d      = 1'b0;
          gen_init    = 1'b1;
          cyc_d       = 1'b1;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          state_d = GAP;
          if (is_read && (wbm_dat_i != exp_dat)) begin
            if (err_q == 8'd0) begin
              fail_addr_d = gen_adr;
              fail_data_d = wbm_dat_i;
            end
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end
          if (is_read && cfg.wr) begin
            wr_step_d = 1'b1;          // same row, write half next
          end else begin
            wr_step_d = 1'b0;
            if (!gen_last) begin
              gen_step = 1'b1;
            end else if (phase_q == P3) begin
              last_d = 1'b1;
            end else begin
              phase_d       = phase_nxt;
              gen_init      = 1'b1;
              gen_init_down = nxt_cfg.down;
            end
          end
        end
`ifdef BIST_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          cyc_d     = 1'b0;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end

      GAP: begin
        // One idle cycle so the slave's request/ack toggle logic re-arms.
        if (last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_q == 8'd0) && !timeout_q;
          state_d = DONE;
        end else begin
          cyc_d   = 1'b1;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      phase_q     <= P0;
      wr_step_q   <= 1'b0;
      last_q      <= 1'b0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cyc_q       <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
`ifdef BIST_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wr_step_q   <= wr_step_d;
      last_q      <= last_d;
      pat_q       <= pat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      cyc_q       <= cyc_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
`ifdef BIST_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign error_count_o = err_q;
  assign fail_addr_o   = fail_addr_q;
  assign fail_data_o   = fail_data_q;
`ifdef BIST_TIMEOUT_EN
  assign timeout_o     = timeout_q;
`else
  assign timeout_o     = 1'b0;
`endif

  // Bus fields are held at zero outside a cycle so the idle bus is quiet.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_sel_o = 4'hF;
  assign wbm_we_o  = cyc_q && !is_read;
  assign wbm_adr_o = cyc_q ? gen_adr : 32'h0;
  assign wbm_dat_o = (cyc_q && !is_read) ? wr_dat : 32'h0;

endmodule

// File: tb/tb_wb_march_bist.sv
// Directed bench for wb_march_bist with a 16-row Wishbone SRAM model.
// Latency: slave acks lat+1 cycles after it sees the strobe.
// Backpressure: slave can withhold ack entirely (timeout case, BIST_TIMEOUT_EN builds).
module tb_wb_march_bist;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] PAT  = 32'hA5A5_5A5A;
  localparam logic [31:0] PAT2 = 32'h0123_4567;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start_i;
  logic [31:0] pattern_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [7:0]  error_count_o;
  logic [31:0] fail_addr_o, fail_data_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_march_bist #(
    .NO_OF_ROWS (16),
    .BASE_ADDR  (BASE),
    .TIMEOUT    (15)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .start_i       (start_i),
    .pattern_i     (pattern_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .timeout_o     (timeout_o),
    .error_count_o (error_count_o),
    .fail_addr_o   (fail_addr_o),
    .fail_data_o   (fail_data_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_ack_i     (wbm_ack_i)
  );

  // SRAM slave model; row 9 bit 0 reads as 1 when stuck_en is set.
  logic [31:0] mem [0:15];
  int          lat = 1;
  logic        ack_en = 1'b1;
  logic        stuck_en = 1'b0;
  int          wait_cnt = 0;
  logic [3:0]  srow;
  assign srow = wbm_adr_o[5:2];

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_ack_i <= 1'b0;
      wait_cnt  <= 0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_en) begin
      if (wait_cnt >= lat) begin
        wbm_ack_i <= 1'b1;
        wait_cnt  <= 0;
        if (wbm_we_o) mem[srow] <= wbm_dat_o;
        else wbm_dat_i <= (stuck_en && srow == 4'd9) ? (mem[srow] | 32'h1) : mem[srow];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  // Protocol monitor and transaction log (free-running counters).
  int          txn_cnt = 0, rd_hi_cnt = 0, proto_errs = 0, cyc_cycles = 0, gap_stage = 0;
  logic [31:0] log_adr [0:1023];
  logic [31:0] log_dat [0:1023];
  logic        log_we  [0:1023];

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      gap_stage = 0;
    end else begin
      if (wbm_stb_o !== wbm_cyc_o) proto_errs++;
      if (wbm_sel_o !== 4'hF) proto_errs++;
      if (wbm_cyc_o) cyc_cycles++;
      if (gap_stage == 1) begin
        if (wbm_cyc_o !== 1'b0) proto_errs++;
        gap_stage = 2;
      end else if (gap_stage == 2) begin
        if (wbm_cyc_o !== busy_o) proto_errs++;
        gap_stage = 0;
      end
      if (wbm_cyc_o && wbm_ack_i) begin
        if (wbm_adr_o[31:16] !== 16'h3000 || wbm_adr_o[1:0] !== 2'b00) proto_errs++;
        if (txn_cnt < 1024) begin
          log_adr[txn_cnt] = wbm_adr_o;
          log_dat[txn_cnt] = wbm_dat_o;
          log_we[txn_cnt]  = wbm_we_o;
        end
        if (!wbm_we_o && wbm_adr_o[5]) rd_hi_cnt++;
        txn_cnt++;
        gap_stage = 1;
      end
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (done_o !== 1'b1 && i < budget) begin
      @(negedge wb_clk_i);
      i++;
    end
    check(tag, 32'(done_o), 32'd1);
  endtask

  task automatic wait_txn(input string tag, input int target, input int budget);
    int i = 0;
    while (txn_cnt < target && i < budget) begin
      @(negedge wb_clk_i);
      i++;
    end
    check(tag, 32'(txn_cnt >= target), 32'd1);
  endtask

  task automatic pulse_start(input logic [31:0] pat);
    @(negedge wb_clk_i);
    start_i   = 1'b1;
    pattern_i = pat;
    @(negedge wb_clk_i);
    start_i   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, pass_o, timeout_o}), 32'd0);
    check({tag, "_err"}, 32'(error_count_o), 32'd0);
    check({tag, "_faddr"}, fail_addr_o, 32'd0);
    check({tag, "_fdata"}, fail_data_o, 32'd0);
    check({tag, "_bus"}, wbm_adr_o | wbm_dat_o, 32'd0);
  endtask

  int base, pbase, rbase, cbase;

  initial begin
    wb_rst_i  = 1'b1;
    start_i   = 1'b0;
    pattern_i = 32'h0;
    repeat (3) @(negedge wb_clk_i);
    check_reset_outputs("rst");
    check("rst_sel", 32'(wbm_sel_o), 32'hF);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // A: fault-free run, ascending/descending order and data spot checks.
    base = txn_cnt; pbase = proto_errs; rbase = rd_hi_cnt;
    pulse_start(PAT);
    check("a_busy", 32'(busy_o), 32'd1);
    wait_done("a_done", 3000);
    check("a_txn", 32'(txn_cnt - base), 32'd96);
    check("a_pass", 32'({pass_o, busy_o, timeout_o}), 32'b100);
    check("a_err", 32'(error_count_o), 32'd0);
    check("a_proto", 32'(proto_errs - pbase), 32'd0);
    check("a_rd_hi", 32'(rd_hi_cnt - rbase), 32'd24);
    check("a_t0", {log_adr[base], log_dat[base]} == {BASE, PAT} && log_we[base], 32'd1);
    check("a_t17_dat", log_dat[base + 17], ~PAT);
    check("a_t48_adr", log_adr[base + 48], 32'h3000_003C);
    check("a_t48_we", 32'(log_we[base + 48]), 32'd0);
    check("a_t49_dat", log_dat[base + 49], PAT);
    check("a_t95_adr", log_adr[base + 95], BASE);
    check("a_t95_we", 32'(log_we[base + 95]), 32'd0);
    check("a_mem9", mem[9], PAT);

    // B: stuck-at-1 on row 9 bit 0, start ignored mid-run.
    lat = 0; stuck_en = 1'b1;
    base = txn_cnt;
    pulse_start(PAT);
    wait_txn("b_wait30", base + 30, 1000);
    @(negedge wb_clk_i);
    start_i = 1'b1; pattern_i = 32'hFFFF_FFFF;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    wait_done("b_done", 3000);
    check("b_txn", 32'(txn_cnt - base), 32'd96);
    check("b_err", 32'(error_count_o), 32'd2);
    check("b_faddr", fail_addr_o, 32'h3000_0024);
    check("b_fdata", fail_data_o, 32'hA5A5_5A5B);
    check("b_pass", 32'(pass_o), 32'd0);

    // C: restart from DONE clears results; reset mid-transaction aborts.
    lat = 1;
    base = txn_cnt;
    pulse_start(PAT);
    check("c_clr", 32'({done_o, busy_o, error_count_o}), 32'h100);
    check("c_clr_faddr", fail_addr_o, 32'd0);
    wait_txn("c_wait40", base + 40, 1000);
    begin
      int i = 0;
      @(negedge wb_clk_i);
      while (!(wbm_cyc_o && !wbm_ack_i) && i < 50) begin
        @(negedge wb_clk_i);
        i++;
      end
    end
    check("c_in_req", 32'(wbm_cyc_o), 32'd1);
    check("c_err_pre", 32'(error_count_o), 32'd1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check_reset_outputs("c_rst");
    wb_rst_i = 1'b0;

    // D: clean run after reset.
    stuck_en = 1'b0;
    base = txn_cnt; pbase = proto_errs;
    pulse_start(PAT2);
    wait_done("d_done", 3000);
    check("d_txn", 32'(txn_cnt - base), 32'd96);
    check("d_pass", 32'({pass_o, error_count_o}), 32'h100);
    check("d_t17_dat", log_dat[base + 17], ~PAT2);
    check("d_mem5", mem[5], PAT2);
    check("d_proto", 32'(proto_errs - pbase), 32'd0);

`ifdef BIST_TIMEOUT_EN
    // E: slave never acks.
    ack_en = 1'b0;
    cbase = cyc_cycles;
    pulse_start(PAT);
    wait_done("e_done", 200);
    check("e_cyc_cycles", 32'(cyc_cycles - cbase), 32'd15);
    check("e_flags", 32'({timeout_o, pass_o, busy_o, wbm_cyc_o}), 32'b1000);
`else
    check("e_timeout_tied", 32'(timeout_o), 32'd0);
`endif

    check("proto_total", 32'(proto_errs), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
